// File: rtl/conv_pkg.sv
// conv_pkg: shared types for the convolution control FSM.
// Holds the state encoding used by conv_controller.
`timescale 1ns/1ps

package conv_pkg;

    // All eight encodings are named; the controller still maps anything
    // unexpected (e.g. X after power-up glitches) back to IDLE.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LD_COEFF  = 3'd1,
        LD_SAMPLE = 3'd2,
        START     = 3'd3,
        CONV      = 3'd4,
        RESULT    = 3'd5,
        SHIFT     = 3'd6,
        DONE      = 3'd7
    } conv_state_t;

endpackage

// File: rtl/conv_controller.sv
// conv_controller: Moore FSM sequencing coefficient load, sample load,
// convolution start, result hand-off and sample-window shift.
//
// Ports:
//   clk             system clock, rising edge
//   n_rst           asynchronous active-low reset
//   conv_en         run enable; low aborts to IDLE
//   coeff_loaded    coefficient buffer load finished
//   sample_loaded   sample buffer load finished
//   conv_complete   MAC engine convolution finished
//   sample_complete input stream exhausted (looked at in RESULT only)
//   load_coeff      level request: load coefficients
//   load_sample     level request: load samples
//   start_conv      one-cycle pulse: start convolution
//   shift           one-cycle pulse: shift sample window
//   result_ready    one-cycle pulse: result valid downstream
`timescale 1ns/1ps

module conv_controller
    import conv_pkg::*;
(
    input  logic clk,
    input  logic n_rst,
    input  logic conv_en,
    input  logic coeff_loaded,
    input  logic sample_loaded,
    input  logic conv_complete,
    input  logic sample_complete,
    output logic load_coeff,
    output logic load_sample,
    output logic start_conv,
    output logic shift,
    output logic result_ready
);

    conv_state_t state_q;
    conv_state_t state_d;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Abort wins over every other transition; done flags only matter in
    // the state that is waiting for them.
    always_comb begin
        state_d = state_q;
        if (!conv_en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:      state_d = LD_COEFF;
                LD_COEFF:  if (coeff_loaded)  state_d = LD_SAMPLE;
                LD_SAMPLE: if (sample_loaded) state_d = START;
                START:     state_d = CONV;
                CONV:      if (conv_complete) state_d = RESULT;
                RESULT:    state_d = sample_complete ? DONE : SHIFT;
                // Coefficients stay loaded; only the sample window moves.
                SHIFT:     state_d = LD_SAMPLE;
                DONE:      state_d = DONE;
                default:   state_d = IDLE;
            endcase
        end
    end

    // Outputs depend on the registered state only, so they are glitch-free
    // with respect to the inputs and one-hot by construction.
    always_comb begin
        load_coeff   = 1'b0;
        load_sample  = 1'b0;
        start_conv   = 1'b0;
        shift        = 1'b0;
        result_ready = 1'b0;
        case (state_q)
            LD_COEFF:  load_coeff   = 1'b1;
            LD_SAMPLE: load_sample  = 1'b1;
            START:     start_conv   = 1'b1;
            SHIFT:     shift        = 1'b1;
            RESULT:    result_ready = 1'b1;
            default:   ;
        endcase
    end

endmodule

// File: tb/tb_conv_controller.sv
// tb_conv_controller: scenario-driven bench for conv_controller.
// Expected output vectors are queued as stimulus is applied.
`timescale 1ns/100ps

module tb_conv_controller;

    // Input vector: {conv_en, coeff_loaded, sample_loaded,
    //                conv_complete, sample_complete}
    localparam logic [4:0] I0  = 5'b00000;
    localparam logic [4:0] EN  = 5'b10000;
    localparam logic [4:0] CL  = 5'b01000;
    localparam logic [4:0] SL  = 5'b00100;
    localparam logic [4:0] CC  = 5'b00010;
    localparam logic [4:0] SCP = 5'b00001;

    // Output vector: {load_coeff, load_sample, start_conv,
    //                 shift, result_ready}
    localparam logic [4:0] Z  = 5'b00000;
    localparam logic [4:0] LC = 5'b10000;
    localparam logic [4:0] LS = 5'b01000;
    localparam logic [4:0] SC = 5'b00100;
    localparam logic [4:0] SH = 5'b00010;
    localparam logic [4:0] RR = 5'b00001;

    logic clk;
    logic n_rst;
    logic conv_en;
    logic coeff_loaded;
    logic sample_loaded;
    logic conv_complete;
    logic sample_complete;
    logic load_coeff;
    logic load_sample;
    logic start_conv;
    logic shift;
    logic result_ready;
    logic [4:0] outs;

    int checks = 0;
    int errors = 0;
    logic [4:0] sb [$];

    assign outs = {load_coeff, load_sample, start_conv, shift, result_ready};

    conv_controller dut (
        .clk             (clk),
        .n_rst           (n_rst),
        .conv_en         (conv_en),
        .coeff_loaded    (coeff_loaded),
        .sample_loaded   (sample_loaded),
        .conv_complete   (conv_complete),
        .sample_complete (sample_complete),
        .load_coeff      (load_coeff),
        .load_sample     (load_sample),
        .start_conv      (start_conv),
        .shift           (shift),
        .result_ready    (result_ready)
    );

    initial clk = 1'b0;
    always #1.25 clk = ~clk;

    // Outputs must be one-hot or all zero in every cycle.
    always @(negedge clk) begin
        checks++;
        if ($isunknown(outs) || !$onehot0(outs)) begin
            errors++;
            $display("FAIL onehot at %0t: outs=%b", $time, outs);
        end
    end

    task automatic apply_inputs(input logic [4:0] v);
        {conv_en, coeff_loaded, sample_loaded,
         conv_complete, sample_complete} = v;
    endtask

    task automatic test_reset();
        logic [4:0] want;
        apply_inputs(EN);
        sb.push_back(LC);
        @(posedge clk); #0.8;
        want = sb.pop_front();
        checks++;
        if (outs !== want) begin
            errors++;
            $display("FAIL reset_pre: got %b want %b", outs, want);
        end
        @(negedge clk);
        n_rst = 1'b0;
        sb.push_back(Z);
        #0.5;
        want = sb.pop_front();
        checks++;
        if (outs !== want) begin
            errors++;
            $display("FAIL reset_async: got %b want %b", outs, want);
        end
        sb.push_back(Z);
        @(posedge clk); #0.8;
        want = sb.pop_front();
        checks++;
        if (outs !== want) begin
            errors++;
            $display("FAIL reset_held: got %b want %b", outs, want);
        end
        apply_inputs(I0);
        #0.2;
        n_rst = 1'b1;
        sb.push_back(Z);
        #0.8;
        want = sb.pop_front();
        checks++;
        if (outs !== want) begin
            errors++;
            $display("FAIL reset_release: got %b want %b", outs, want);
        end
        sb.push_back(Z);
        @(posedge clk); #0.8;
        want = sb.pop_front();
        checks++;
        if (outs !== want) begin
            errors++;
            $display("FAIL reset_idle: got %b want %b", outs, want);
        end
    endtask

    task automatic test_single_window();
        logic [9:0] steps [$];
        logic [4:0] want;
        steps = '{
            {EN, LC}, {EN | CL, LS}, {EN | SL, SC}, {EN, Z},
            {EN | CC | SCP, RR}, {EN | SCP, Z}, {EN, Z}, {I0, Z}
        };
        foreach (steps[i]) begin
            apply_inputs(steps[i][9:5]);
            sb.push_back(steps[i][4:0]);
            @(posedge clk); #0.8;
            want = sb.pop_front();
            checks++;
            if (outs !== want) begin
                errors++;
                $display("FAIL single_window step %0d: got %b want %b",
                         i, outs, want);
            end
        end
    endtask

    task automatic test_multi_window();
        logic [9:0] steps [$];
        logic [4:0] want;
        int n_rr = 0;
        int n_sh = 0;
        steps = '{
            {EN, LC}, {EN | CL, LS}, {EN | SL, SC}, {EN | CL, Z},
            {EN | CC, RR}, {EN, SH}, {EN, LS}, {EN | SL, SC},
            {EN, Z}, {EN | CC, RR}, {EN, SH}, {EN, LS},
            {EN | SL, SC}, {EN, Z}, {EN | CC, RR}, {EN | SCP, Z},
            {I0, Z}
        };
        foreach (steps[i]) begin
            apply_inputs(steps[i][9:5]);
            sb.push_back(steps[i][4:0]);
            @(posedge clk); #0.8;
            if (result_ready === 1'b1) n_rr++;
            if (shift === 1'b1) n_sh++;
            want = sb.pop_front();
            checks++;
            if (outs !== want) begin
                errors++;
                $display("FAIL multi_window step %0d: got %b want %b",
                         i, outs, want);
            end
        end
        checks++;
        if (n_rr !== 3) begin
            errors++;
            $display("FAIL multi_rr_count: got %0d want 3", n_rr);
        end
        checks++;
        if (n_sh !== 2) begin
            errors++;
            $display("FAIL multi_shift_count: got %0d want 2", n_sh);
        end
    endtask

    task automatic test_hold();
        logic [9:0] steps [$];
        logic [4:0] want;
        steps = '{
            {EN, LC}, {EN | SL | CC, LC}, {EN, LC}, {EN | SCP, LC},
            {EN, LC}, {EN, LC}, {EN | CL, LS}, {I0, Z}
        };
        foreach (steps[i]) begin
            apply_inputs(steps[i][9:5]);
            sb.push_back(steps[i][4:0]);
            @(posedge clk); #0.8;
            want = sb.pop_front();
            checks++;
            if (outs !== want) begin
                errors++;
                $display("FAIL hold step %0d: got %b want %b",
                         i, outs, want);
            end
        end
    endtask

    task automatic test_abort();
        logic [9:0] steps [$];
        logic [4:0] want;
        steps = '{
            {EN, LC}, {EN | CL, LS}, {EN | SL, SC}, {EN, Z},
            {CC, Z}, {EN, LC}, {EN | CL, LS}, {SL, Z}, {I0, Z}
        };
        foreach (steps[i]) begin
            apply_inputs(steps[i][9:5]);
            sb.push_back(steps[i][4:0]);
            @(posedge clk); #0.8;
            want = sb.pop_front();
            checks++;
            if (outs !== want) begin
                errors++;
                $display("FAIL abort step %0d: got %b want %b",
                         i, outs, want);
            end
        end
    endtask

    task automatic test_async_reset_ld_sample();
        logic [9:0] steps [$];
        logic [4:0] want;
        steps = '{ {EN, LC}, {EN | CL, LS}, {EN, LS} };
        foreach (steps[i]) begin
            apply_inputs(steps[i][9:5]);
            sb.push_back(steps[i][4:0]);
            @(posedge clk); #0.8;
            want = sb.pop_front();
            checks++;
            if (outs !== want) begin
                errors++;
                $display("FAIL async_pre step %0d: got %b want %b",
                         i, outs, want);
            end
        end
        @(negedge clk);
        n_rst = 1'b0;
        sb.push_back(Z);
        #0.5;
        want = sb.pop_front();
        checks++;
        if (outs !== want) begin
            errors++;
            $display("FAIL async_ld_sample: got %b want %b", outs, want);
        end
        apply_inputs(I0);
        @(posedge clk); #0.8;
        n_rst = 1'b1;
        sb.push_back(Z);
        @(posedge clk); #0.8;
        want = sb.pop_front();
        checks++;
        if (outs !== want) begin
            errors++;
            $display("FAIL async_after: got %b want %b", outs, want);
        end
    endtask

    task automatic test_early_flags();
        logic [9:0] steps [$];
        logic [4:0] want;
        logic [4:0] all_in;
        all_in = EN | CL | SL | CC | SCP;
        steps = '{
            {all_in, LC}, {all_in, LS}, {all_in, SC}, {all_in, Z},
            {all_in, RR}, {all_in, Z}, {all_in, Z}, {I0, Z}
        };
        foreach (steps[i]) begin
            apply_inputs(steps[i][9:5]);
            sb.push_back(steps[i][4:0]);
            @(posedge clk); #0.8;
            want = sb.pop_front();
            checks++;
            if (outs !== want) begin
                errors++;
                $display("FAIL early_flags step %0d: got %b want %b",
                         i, outs, want);
            end
        end
    endtask

    initial begin
        n_rst = 1'b0;
        apply_inputs(I0);
        repeat (2) @(posedge clk);
        #0.8;
        n_rst = 1'b1;
        @(posedge clk); #0.8;
        test_reset();
        test_single_window();
        test_multi_window();
        test_hold();
        test_abort();
        test_async_reset_ld_sample();
        test_early_flags();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries want 0",
                     sb.size());
        end
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
